// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
//   Program-counter and next-address stage. Holds the architectural PC,
//   computes PC+4 and PC+br_offset through two carry-lookahead adders,
//   and picks the next PC from halt/stall/jump/branch/sequential inputs.
//
// Ports
//   clk        in   1   rising-edge clock
//   rst        in   1   synchronous active-high reset
//   stall      in   1   hold PC this cycle
//   halt       in   1   halt decoded at current PC
//   br_taken   in   1   conditional branch taken
//   br_offset  in  32   signed byte offset, target = pc + br_offset
//   jr_valid   in   1   jump-register / absolute jump
//   jr_target  in  32   absolute byte target
//   pc         out 32   current instruction address (registered)
//   pc_plus4   out 32   pc + 4 (combinational)
//   fetch_en   out  1   instruction memory read enable (RUN only)
//   halted     out  1   unit is HALTED
//   fault      out  1   misaligned target seen, sticky until rst
//   retired    out 32   count of completed PC advances

// CLA32BitNoCarry
//   32-bit adder, modulo 2^32. Eight 4-bit lookahead groups; group
//   generate/propagate terms chain the group carries. No carry-out.
//
// Ports
//   a, b  in  32  operands
//   sum   out 32  a + b mod 2^32
module CLA32BitNoCarry (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum
);

  // Bit 31's generate would only feed the discarded carry-out.
  logic [30:0] g;
  logic [31:0] p;
  logic [31:0] c;
  logic [7:0]  gc;
  logic [6:0]  gg;
  logic [6:0]  gp;

  assign g = a[30:0] & b[30:0];
  assign p = a ^ b;
  assign gc[0] = 1'b0;

  for (genvar k = 0; k < 8; k++) begin : g_grp
    assign c[4*k]   = gc[k];
    assign c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
    assign c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
                    | (p[4*k+1] & p[4*k] & gc[k]);
    assign c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                    | (p[4*k+2] & p[4*k+1] & g[4*k])
                    | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
    if (k < 7) begin : g_gp
      assign gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2])
                   | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                   | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      assign gp[k] = &p[4*k+3:4*k];
      assign gc[k+1] = gg[k] | (gp[k] & gc[k]);
    end
  end

  assign sum = p ^ c;

endmodule

// State table
//   BOOT   | one bubble cycle after reset, pc held, no fetch
//   RUN    | fetching; pc advances, redirects, or holds on stall
//   HALTED | halt seen; absorbing until rst
//   FAULT  | misaligned target at load; absorbing until rst
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        halt,
  input  logic        br_taken,
  input  logic [31:0] br_offset,
  input  logic        jr_valid,
  input  logic [31:0] jr_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_en,
  output logic        halted,
  output logic        fault,
  output logic [31:0] retired
);

  typedef enum logic [1:0] {BOOT, RUN, HALTED, FAULT} state_t;

  state_t      state;
  logic [31:0] br_target;
  logic        pend_valid;
  logic [31:0] pend_target;
  logic [31:0] next_pc;
  logic        is_redirect;
  logic        misaligned;

  CLA32BitNoCarry u_add_plus4 (
    .a   (pc),
    .b   (32'd4),
    .sum (pc_plus4)
  );

  CLA32BitNoCarry u_add_branch (
    .a   (pc),
    .b   (br_offset),
    .sum (br_target)
  );

  // A pending redirect outranks fresh ones; fresh jr outranks br.
  always_comb begin
    next_pc     = pc_plus4;
    is_redirect = 1'b0;
    if (pend_valid) begin
      next_pc     = pend_target;
      is_redirect = 1'b1;
    end else if (jr_valid) begin
      next_pc     = jr_target;
      is_redirect = 1'b1;
    end else if (br_taken) begin
      next_pc     = br_target;
      is_redirect = 1'b1;
    end
  end

  // Sequential path cannot misalign since pc itself is always aligned.
  assign misaligned = is_redirect && (next_pc[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      fetch_en    <= 1'b0;
      halted      <= 1'b0;
      fault       <= 1'b0;
      retired     <= 32'd0;
      pend_valid  <= 1'b0;
      pend_target <= 32'd0;
    end else begin
      case (state)
        BOOT: begin
          state    <= RUN;
          fetch_en <= 1'b1;
        end
        RUN: begin
          if (halt) begin
            state    <= HALTED;
            halted   <= 1'b1;
            fetch_en <= 1'b0;
          end else if (stall) begin
            // First redirect seen during a stall is remembered; the
            // alignment check waits until it actually loads.
            if (!pend_valid && (jr_valid || br_taken)) begin
              pend_valid  <= 1'b1;
              pend_target <= jr_valid ? jr_target : br_target;
            end
          end else if (misaligned) begin
            state    <= FAULT;
            fault    <= 1'b1;
            fetch_en <= 1'b0;
          end else begin
            pc         <= next_pc;
            retired    <= retired + 32'd1;
            pend_valid <= 1'b0;
          end
        end
        HALTED: begin
        end
        FAULT: begin
        end
        default: begin
          state    <= BOOT;
          fetch_en <= 1'b0;
        end
      endcase
    end
  end

endmodule
